// File: rtl/vga_out_stage.sv
// vga_out_stage: VGA raster timing generator and 3-3-2 to 4-4-4 colour output stage
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   RGBIn[7:0]            colour from the objects mux {R[2:0],G[2:0],B[1:0]}
//   pixelX/pixelY[10:0]   raw horizontal/vertical counters
//   startOfFrame          high while the counters sit at (0,0)
//   frameCount[7:0]       frames completed since reset
//   red/green/blue[3:0]   DAC colour, zero while blanked
//   hSyncN/vSyncN/blank   active-low syncs and blanking, aligned with the colour
module vga_out_stage #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  frameCount,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        blank
);
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HSS = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HT  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VSS = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSE = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VT  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]  frame_q, frame_d;
  logic        h_wrap, v_wrap;
  // each delay stage holds {act, hs, vs}; the last stage lines up with RGBIn
  logic [2:0]  dly_q [PIPE_DELAY];
  logic [2:0]  raw, tap;
  logic [3:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        hsync_q, vsync_q, blank_q;
  always_comb begin
    h_wrap  = hcnt_q == HT - 11'd1;
    v_wrap  = vcnt_q == VT - 11'd1;
    hcnt_d  = h_wrap ? '0 : hcnt_q + 11'd1;
    vcnt_d  = h_wrap ? (v_wrap ? '0 : vcnt_q + 11'd1) : vcnt_q;
    frame_d = (h_wrap && v_wrap) ? frame_q + 8'd1 : frame_q;
    raw     = {hcnt_q < HA && vcnt_q < VA,
               !(hcnt_q >= HSS && hcnt_q < HSE),
               !(vcnt_q >= VSS && vcnt_q < VSE)};
    tap     = dly_q[PIPE_DELAY-1];
    red_d   = tap[2] ? {RGBIn[7:5], RGBIn[7]} : 4'd0;
    green_d = tap[2] ? {RGBIn[4:2], RGBIn[4]} : 4'd0;
    blue_d  = tap[2] ? {RGBIn[1:0], RGBIn[1:0]} : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b011;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      dly_q[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= tap[1];
      vsync_q <= tap[0];
      blank_q <= !tap[2];
    end
  end
  assign pixelX       = hcnt_q;
  assign pixelY       = vcnt_q;
  assign startOfFrame = hcnt_q == 11'd0 && vcnt_q == 11'd0;
  assign frameCount   = frame_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign hSyncN       = hsync_q;
  assign vSyncN       = vsync_q;
  assign blank        = blank_q;
endmodule

// File: tb/tb_vga_out_stage.sv
// tb_vga_out_stage: directed self-checking bench for vga_out_stage
module tb_vga_out_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic [7:0]  rgb_f, rgb_a, rgb_s;
  logic [10:0] px_f, py_f, px_a, py_a, px_s, py_s;
  logic        sof_f, sof_a, sof_s;
  logic [7:0]  fc_f, fc_a, fc_s;
  logic [3:0]  r_f, g_f, b_f, r_a, g_a, b_a, r_s, g_s, b_s;
  logic        hs_f, vs_f, bl_f, hs_a, vs_a, bl_a, hs_s, vs_s, bl_s;
  vga_out_stage u_full (
    .clk(clk), .reset(reset), .RGBIn(rgb_f), .pixelX(px_f), .pixelY(py_f),
    .startOfFrame(sof_f), .frameCount(fc_f), .red(r_f), .green(g_f), .blue(b_f),
    .hSyncN(hs_f), .vSyncN(vs_f), .blank(bl_f));
  vga_out_stage #(.PIPE_DELAY(3)) u_pd3 (
    .clk(clk), .reset(reset), .RGBIn(rgb_a), .pixelX(px_a), .pixelY(py_a),
    .startOfFrame(sof_a), .frameCount(fc_a), .red(r_a), .green(g_a), .blue(b_a),
    .hSyncN(hs_a), .vSyncN(vs_a), .blank(bl_a));
  vga_out_stage #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                  .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_small (
    .clk(clk), .reset(reset), .RGBIn(rgb_s), .pixelX(px_s), .pixelY(py_s),
    .startOfFrame(sof_s), .frameCount(fc_s), .red(r_s), .green(g_s), .blue(b_s),
    .hSyncN(hs_s), .vSyncN(vs_s), .blank(bl_s));
  int checks = 0, errors = 0, cyc = 0, bad = 0;
  logic        blank_chk = 1'b0;
  logic [10:0] hx [4], hy [4];
  logic [7:0]  ax [4];
  int p0, f0, f1, r0, nvis, nsof, py14, vf, vr, nf, nr;
  int sofc [3], fcs [3];
  logic ph, pb, pv, pba, nxt;
  logic [11:0] prgb;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    logic eb;
    @(negedge clk);
    cyc++;
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
      ax[i] = ax[i-1];
    end
    hx[0] = px_f;
    hy[0] = py_f;
    ax[0] = px_a[7:0];
    rgb_a = ax[3];
    if (blank_chk) begin
      eb = !(hx[3] < 11'd640 && hy[3] < 11'd480);
      if (bl_f !== eb || {r_f, g_f, b_f} !== (eb ? 12'h000 : 12'hFFF)) bad++;
    end
  endtask
  initial begin
    reset = 1'b1;
    rgb_f = 8'hFF;
    rgb_s = 8'hFF;
    rgb_a = 8'h00;
    for (int i = 0; i < 4; i++) begin
      hx[i] = '0;
      hy[i] = '0;
      ax[i] = '0;
    end
    repeat (5) tick;
    chk("rst_rgb", {r_f, g_f, b_f}, 12'h000);
    chk("rst_hsync", hs_f, 1);
    chk("rst_vsync", vs_f, 1);
    chk("rst_blank", bl_f, 1);
    chk("rst_sof", sof_f, 1);
    chk("rst_pix", {py_f, px_f}, 0);
    chk("rst_fcount", fc_f, 0);
    reset = 1'b0;
    chk("rel_pix0", {py_f, px_f}, 0);
    chk("rel_blank0", bl_f, 1);
    tick;
    chk("rel_pix1", px_f, 1);
    chk("rel_blank1", bl_f, 1);
    tick;
    chk("rel_blank2", bl_f, 1);
    tick;
    chk("rel_first_blank", bl_f, 0);
    chk("rel_first_rgb", {r_f, g_f, b_f}, 12'hFFF);
    blank_chk = 1'b1;
    p0 = 0; f0 = 0; f1 = 0; r0 = 0; nvis = 0;
    ph = hs_f;
    pb = bl_f;
    for (int i = 0; i < 1700; i++) begin
      tick;
      if (px_f == 11'd656 && p0 == 0) p0 = cyc;
      if (ph && !hs_f) begin
        if (f0 == 0) f0 = cyc;
        else if (f1 == 0) f1 = cyc;
      end
      if (!ph && hs_f && r0 == 0) r0 = cyc;
      if (pb && !bl_f) begin
        nvis++;
        chk("line_first_vis", {r_f, g_f, b_f}, 12'hFFF);
      end
      ph = hs_f;
      pb = bl_f;
    end
    blank_chk = 1'b0;
    chk("hsync_delay", f0 - p0, 3);
    chk("hsync_width", r0 - f0, 96);
    chk("line_period", f1 - f0, 800);
    chk("blank_bad", bad, 0);
    chk("vis_starts", nvis, 2);
    for (int i = 0; i < 1000 && !(px_f == 11'd100 && py_f < 11'd480); i++) tick;
    chk("col_wait", px_f, 100);
    rgb_f = 8'hE3;
    tick;
    chk("col_e3", {r_f, g_f, b_f}, 12'hF0F);
    chk("col_e3_blank", bl_f, 0);
    rgb_f = 8'h49;
    tick;
    chk("col_49", {r_f, g_f, b_f}, 12'h445);
    rgb_f = 8'hFF;
    for (int i = 0; i < 1000 && !(px_s == 11'd10 && py_s == 11'd8); i++) tick;
    chk("mid_wait", {py_s, px_s}, {11'd8, 11'd10});
    reset = 1'b1;
    tick;
    chk("mid_rgb", {r_s, g_s, b_s}, 12'h000);
    chk("mid_sync", {hs_s, vs_s, bl_s}, 3'b111);
    chk("mid_sof", sof_s, 1);
    chk("mid_pix", {py_s, px_s}, 0);
    chk("mid_fcount", fc_s, 0);
    chk("mid_full_out", {r_f, g_f, b_f, hs_f, vs_f, bl_f}, 15'h0007);
    repeat (4) tick;
    reset = 1'b0;
    chk("mid_rel_pix", {py_s, px_s}, 0);
    nsof = 0; py14 = 0; vf = 0; vr = 0;
    pv = vs_s;
    for (int i = 0; i < 1300; i++) begin
      if (sof_s) begin
        if (nsof < 3) begin
          sofc[nsof] = cyc;
          fcs[nsof] = int'(fc_s);
        end
        nsof++;
      end
      if (py_s == 11'd14 && px_s == 11'd0 && py14 == 0) py14 = cyc;
      if (pv && !vs_s && vf == 0) vf = cyc;
      if (!pv && vs_s && vf != 0 && vr == 0) vr = cyc;
      pv = vs_s;
      tick;
    end
    chk("sof_count", nsof, 3);
    chk("sof_period0", sofc[1] - sofc[0], 608);
    chk("sof_period1", sofc[2] - sofc[1], 608);
    chk("fcount0", fcs[0], 0);
    chk("fcount1", fcs[1], 1);
    chk("fcount2", fcs[2], 2);
    chk("vsync_delay", vf - py14, 3);
    chk("vsync_width", vr - vf, 64);
    nf = 0; nr = 0; nxt = 1'b0;
    pba = bl_a;
    prgb = {r_a, g_a, b_a};
    for (int i = 0; i < 1800; i++) begin
      tick;
      if (nxt) begin
        chk("align_second", {r_a, g_a, b_a}, 12'h005);
        nxt = 1'b0;
      end
      if (pba && !bl_a) begin
        nf++;
        chk("align_first", {r_a, g_a, b_a}, 12'h000);
        nxt = 1'b1;
      end
      if (!pba && bl_a) begin
        nr++;
        chk("align_last", prgb, 12'h6FF);
      end
      pba = bl_a;
      prgb = {r_a, g_a, b_a};
    end
    chk("align_falls", nf >= 2, 1);
    chk("align_rises", nr >= 2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
